// File: rtl/tribus_arbiter_if.sv
// Bus-side signals of the tri-state bus arbiter.
//   master modport: the requesting side (drives req, observes enables/status).
//   slave modport : the arbiter itself.
// Optional macro ARB_STATS_EN adds the 8-bit grant_total counter.
// Handshake: req is level-sensitive. A master may drive the bus only while
// its en bit is high. en is registered and changes one edge after the req
// value that caused it. Two grants are always separated by at least one
// all-zero en cycle.
interface tribus_arbiter_if #(
  parameter int N_MASTERS = 4
);
  localparam int IW = $clog2(N_MASTERS);

  logic [N_MASTERS-1:0] req;
  logic [N_MASTERS-1:0] en;
  logic [IW-1:0]        grant_id;
  logic                 bus_busy;
`ifdef ARB_STATS_EN
  logic [7:0]           grant_total;
`endif

  modport master (
    output req,
    input  en,
    input  grant_id,
`ifdef ARB_STATS_EN
    input  grant_total,
`endif
    input  bus_busy
  );

  modport slave (
    input  req,
    output en,
    output grant_id,
`ifdef ARB_STATS_EN
    output grant_total,
`endif
    output bus_busy
  );
endinterface

// File: rtl/tribus_arbiter.sv
// Round-robin arbiter producing one-hot enables for a bank of tri-state
// bus buffers. A grant is followed by TURN_CYCLES dead cycles so two
// buffers can never drive the bus at the same time.
// Optional macro ARB_STATS_EN enables the saturating grant_total counter.
// dbg_state exposes the FSM state (0=IDLE, 1=GRANT, 2=TURN).
module tribus_arbiter #(
  parameter int N_MASTERS   = 4,
  parameter int MAX_HOLD    = 8,
  parameter int TURN_CYCLES = 1
) (
  input  logic       clk,
  input  logic       reset,
  tribus_arbiter_if.slave bus,
  output logic [1:0] dbg_state
);
  localparam int IW     = $clog2(N_MASTERS);
  localparam int HOLD_W = 8;
  localparam int TURN_W = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } state_t;

  state_t                state;
  logic [IW-1:0]         last_id;
  logic [HOLD_W-1:0]     hold_cnt;
  logic [TURN_W-1:0]     turn_cnt;

  logic                  win_valid;
  logic [IW-1:0]         win_id;
  logic [N_MASTERS-1:0]  win_hot;
  logic [N_MASTERS-1:0]  cur_hot;
  logic [N_MASTERS-1:0]  others;
  logic                  hold_limit;
  logic                  release_now;
  logic                  turn_done;
  logic                  issue;

  assign dbg_state = state;

  // Round-robin search starting just after the last winner, with wrap.
  always_comb begin
    win_valid = 1'b0;
    win_id    = last_id;
    for (int i = 1; i <= N_MASTERS; i++) begin
      if (!win_valid && bus.req[(int'(last_id) + i) % N_MASTERS]) begin
        win_valid = 1'b1;
        win_id    = IW'((int'(last_id) + i) % N_MASTERS);
      end
    end
  end

  assign win_hot     = {{(N_MASTERS-1){1'b0}}, 1'b1} << win_id;
  assign cur_hot     = {{(N_MASTERS-1){1'b0}}, 1'b1} << bus.grant_id;
  assign others      = bus.req & ~cur_hot;
  // Forced release only matters when someone else is waiting; a lone
  // requester keeps the bus indefinitely.
  assign hold_limit  = (MAX_HOLD != 0) && (hold_cnt == HOLD_W'(MAX_HOLD - 1)) && (|others);
  assign release_now = !bus.req[bus.grant_id] || hold_limit;
  assign turn_done   = (turn_cnt == TURN_W'(TURN_CYCLES - 1));
  assign issue       = win_valid && ((state == IDLE) || (state == TURN && turn_done));

  // FSM with all bus-facing outputs registered; a new grant overrides the
  // per-state updates on the edge it is issued.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      bus.en       <= '0;
      bus.grant_id <= '0;
      bus.bus_busy <= 1'b0;
      hold_cnt     <= '0;
      turn_cnt     <= '0;
      last_id      <= IW'(N_MASTERS - 1);
`ifdef ARB_STATS_EN
      bus.grant_total <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          bus.en       <= '0;
          bus.bus_busy <= 1'b0;
        end
        GRANT: begin
          if (release_now) begin
            bus.en       <= '0;
            bus.bus_busy <= 1'b0;
            turn_cnt     <= '0;
            state        <= TURN;
          end else if (hold_cnt != {HOLD_W{1'b1}}) begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        TURN: begin
          if (turn_done) begin
            state <= IDLE;
          end else begin
            turn_cnt <= turn_cnt + 1'b1;
          end
        end
        default: begin
          state        <= IDLE;
          bus.en       <= '0;
          bus.bus_busy <= 1'b0;
        end
      endcase

      if (issue) begin
        bus.en       <= win_hot;
        bus.grant_id <= win_id;
        bus.bus_busy <= 1'b1;
        last_id      <= win_id;
        hold_cnt     <= '0;
        state        <= GRANT;
`ifdef ARB_STATS_EN
        if (bus.grant_total != 8'hFF) bus.grant_total <= bus.grant_total + 1'b1;
`endif
      end
    end
  end
endmodule

// File: tb/tb_tribus_arbiter.sv
// Directed bench for tribus_arbiter with default parameters
// (4 masters, MAX_HOLD=8, TURN_CYCLES=1).
module tb_tribus_arbiter;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] dbg_state;

  int vectors = 0;
  int miscompares = 0;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_GRANT = 2'd1;
  localparam logic [1:0] S_TURN  = 2'd2;

  tribus_arbiter_if #(.N_MASTERS(4)) bus ();

  tribus_arbiter #(.N_MASTERS(4), .MAX_HOLD(8), .TURN_CYCLES(1)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // Continuous invariant monitor, sampled on the falling edge.
  bit         mon_on = 1'b0;
  logic [3:0] prev_en = 4'b0000;
  always @(negedge clk) begin
    if (mon_on) begin
      vectors++;
      if ($countones(bus.en) > 1) begin
        miscompares++;
        $display("FAIL onehot: en=%b popcount=%0d required <=1", bus.en, $countones(bus.en));
      end
      vectors++;
      if (prev_en != 4'b0000 && bus.en != 4'b0000 && bus.en != prev_en) begin
        miscompares++;
        $display("FAIL no_turnaround: en went %b -> %b required an all-zero cycle", prev_en, bus.en);
      end
      vectors++;
      if (bus.bus_busy !== (|bus.en)) begin
        miscompares++;
        $display("FAIL busy: bus_busy=%b required %b (en=%b)", bus.bus_busy, |bus.en, bus.en);
      end
      prev_en = bus.en;
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    bus.req = 4'b0000;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic idle_out();
    bus.req = 4'b0000;
    repeat (4) tick();
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if (bus.en !== 4'b0000 || bus.grant_id !== 2'd0 || bus.bus_busy !== 1'b0 || dbg_state !== S_IDLE) begin
      miscompares++;
      $display("FAIL reset: en=%b gid=%0d busy=%b st=%0d required 0000/0/0/0",
               bus.en, bus.grant_id, bus.bus_busy, dbg_state);
    end
`ifdef ARB_STATS_EN
    vectors++;
    if (bus.grant_total !== 8'd0) begin
      miscompares++;
      $display("FAIL reset_total: grant_total=%0d required 0", bus.grant_total);
    end
`endif
  endtask

  task automatic test_single();
    do_reset();
    bus.req = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      tick();
      vectors++;
      if (bus.en !== 4'b0001 || bus.grant_id !== 2'd0 || bus.bus_busy !== 1'b1) begin
        miscompares++;
        $display("FAIL single_grant[%0d]: en=%b gid=%0d busy=%b required 0001/0/1",
                 i, bus.en, bus.grant_id, bus.bus_busy);
      end
    end
    bus.req = 4'b0000;
    tick();
    vectors++;
    if (bus.en !== 4'b0000 || dbg_state !== S_TURN || bus.grant_id !== 2'd0) begin
      miscompares++;
      $display("FAIL single_turn: en=%b st=%0d gid=%0d required 0000/2/0", bus.en, dbg_state, bus.grant_id);
    end
    tick();
    vectors++;
    if (bus.en !== 4'b0000 || dbg_state !== S_IDLE || bus.bus_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL single_idle: en=%b st=%0d busy=%b required 0000/0/0", bus.en, dbg_state, bus.bus_busy);
    end
  endtask

  task automatic test_rotation();
    logic [3:0] exp;
    do_reset();
    bus.req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      exp = 4'b0001 << (g % 4);
      for (int c = 0; c < 8; c++) begin
        tick();
        vectors++;
        if (bus.en !== exp || bus.grant_id !== 2'(g % 4)) begin
          miscompares++;
          $display("FAIL rotation g%0d c%0d: en=%b gid=%0d required %b/%0d",
                   g, c, bus.en, bus.grant_id, exp, g % 4);
        end
      end
      if (g < 4) begin
        tick();
        vectors++;
        if (bus.en !== 4'b0000 || dbg_state !== S_TURN) begin
          miscompares++;
          $display("FAIL rotation_gap g%0d: en=%b st=%0d required 0000/2", g, bus.en, dbg_state);
        end
      end
    end
    idle_out();
  endtask

  task automatic test_lone_hold();
    do_reset();
    bus.req = 4'b0100;
    for (int i = 0; i < 30; i++) begin
      tick();
      vectors++;
      if (bus.en !== 4'b0100 || bus.grant_id !== 2'd2) begin
        miscompares++;
        $display("FAIL lone_hold[%0d]: en=%b gid=%0d required 0100/2", i, bus.en, bus.grant_id);
      end
    end
    idle_out();
  endtask

  task automatic test_handoff();
    do_reset();
    bus.req = 4'b0010;
    repeat (3) tick();
    vectors++;
    if (bus.en !== 4'b0010 || bus.grant_id !== 2'd1) begin
      miscompares++;
      $display("FAIL handoff_grant: en=%b gid=%0d required 0010/1", bus.en, bus.grant_id);
    end
    bus.req = 4'b1000;
    tick();
    vectors++;
    if (bus.en !== 4'b0000 || bus.grant_id !== 2'd1 || dbg_state !== S_TURN) begin
      miscompares++;
      $display("FAIL handoff_turn: en=%b gid=%0d st=%0d required 0000/1/2", bus.en, bus.grant_id, dbg_state);
    end
    tick();
    vectors++;
    if (bus.en !== 4'b1000 || bus.grant_id !== 2'd3) begin
      miscompares++;
      $display("FAIL handoff_next: en=%b gid=%0d required 1000/3", bus.en, bus.grant_id);
    end
    idle_out();
  endtask

  task automatic test_simultaneous();
    do_reset();
    bus.req = 4'b0011;
    repeat (8) tick();
    vectors++;
    if (bus.en !== 4'b0001) begin
      miscompares++;
      $display("FAIL simul_hold: en=%b required 0001", bus.en);
    end
    bus.req = 4'b0010;
    tick();
    vectors++;
    if (bus.en !== 4'b0000 || dbg_state !== S_TURN) begin
      miscompares++;
      $display("FAIL simul_turn: en=%b st=%0d required 0000/2", bus.en, dbg_state);
    end
    tick();
    vectors++;
    if (bus.en !== 4'b0010 || bus.grant_id !== 2'd1) begin
      miscompares++;
      $display("FAIL simul_next: en=%b gid=%0d required 0010/1", bus.en, bus.grant_id);
    end
    idle_out();
  endtask

  task automatic test_turn_pulse();
    do_reset();
    bus.req = 4'b0001;
    repeat (2) tick();
    bus.req = 4'b0100;
    tick();
    vectors++;
    if (bus.en !== 4'b0000 || dbg_state !== S_TURN) begin
      miscompares++;
      $display("FAIL pulse_turn: en=%b st=%0d required 0000/2", bus.en, dbg_state);
    end
    bus.req = 4'b0000;
    tick();
    vectors++;
    if (bus.en !== 4'b0000 || dbg_state !== S_IDLE || bus.grant_id !== 2'd0) begin
      miscompares++;
      $display("FAIL pulse_ignored: en=%b st=%0d gid=%0d required 0000/0/0", bus.en, dbg_state, bus.grant_id);
    end
    tick();
    vectors++;
    if (bus.en !== 4'b0000) begin
      miscompares++;
      $display("FAIL pulse_stays_idle: en=%b required 0000", bus.en);
    end
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    bus.req = 4'b1000;
    repeat (2) tick();
    vectors++;
    if (bus.en !== 4'b1000 || bus.grant_id !== 2'd3) begin
      miscompares++;
      $display("FAIL midreset_grant: en=%b gid=%0d required 1000/3", bus.en, bus.grant_id);
    end
    reset   = 1'b1;
    bus.req = 4'b1111;
    tick();
    vectors++;
    if (bus.en !== 4'b0000 || bus.grant_id !== 2'd0 || dbg_state !== S_IDLE) begin
      miscompares++;
      $display("FAIL midreset_clear: en=%b gid=%0d st=%0d required 0000/0/0", bus.en, bus.grant_id, dbg_state);
    end
    reset = 1'b0;
    tick();
    vectors++;
    if (bus.en !== 4'b0001 || bus.grant_id !== 2'd0) begin
      miscompares++;
      $display("FAIL midreset_first: en=%b gid=%0d required 0001/0", bus.en, bus.grant_id);
    end
    idle_out();
  endtask

`ifdef ARB_STATS_EN
  task automatic test_grant_total();
    do_reset();
    bus.req = 4'b1111;
    // Grants land every 9 cycles starting at the first edge: 10 grants in 82 edges.
    repeat (82) tick();
    vectors++;
    if (bus.grant_total !== 8'd10) begin
      miscompares++;
      $display("FAIL total_10: grant_total=%0d required 10", bus.grant_total);
    end
    repeat (2700 - 82) tick();
    vectors++;
    if (bus.grant_total !== 8'd255) begin
      miscompares++;
      $display("FAIL total_sat: grant_total=%0d required 255", bus.grant_total);
    end
    repeat (50) tick();
    vectors++;
    if (bus.grant_total !== 8'd255) begin
      miscompares++;
      $display("FAIL total_hold: grant_total=%0d required 255", bus.grant_total);
    end
    do_reset();
    vectors++;
    if (bus.grant_total !== 8'd0) begin
      miscompares++;
      $display("FAIL total_clear: grant_total=%0d required 0", bus.grant_total);
    end
  endtask
`endif

  initial begin
    bus.req = 4'b0000;
    test_reset();
    mon_on = 1'b1;
    test_single();
    test_rotation();
    test_lone_hold();
    test_handoff();
    test_simultaneous();
    test_turn_pulse();
    test_reset_mid_grant();
`ifdef ARB_STATS_EN
    test_grant_total();
`endif
    mon_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/tribus_arbiter.md
Name: tribus_arbiter

Overview:
- Round-robin arbiter for a shared tri-state data bus. It sits directly upstream of the bank of 4-bit tri-state buffers and generates their one-hot enable inputs.
- Each master drives the bus only while granted. A mandatory dead (turnaround) interval between grants guarantees no two buffers ever drive at once.
- Consumers use grant_id and bus_busy to qualify bus data.

Parameters:
- N_MASTERS, 4, number of requesting masters and tri-state buffers (2..8).
- MAX_HOLD, 8, maximum consecutive grant cycles while another master is pending. 0 = unlimited.
- TURN_CYCLES, 1, dead cycles with all enables low after every grant ends (1..4).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- req  input  N_MASTERS  per-master bus request, level-sensitive
- en  output  N_MASTERS  one-hot tri-state enable, registered; all-zero when bus is free
- grant_id  output  clog2(N_MASTERS)  index of current/last granted master, registered
- bus_busy  output  1  high iff any en bit is high
- grant_total  output  8  saturating grant counter; present only with ARB_STATS_EN

Behaviour:
- One clock, clk. reset is synchronous and active-high, sampled on the rising edge.
- Reset values:
  - en=0, grant_id=0, bus_busy=0, grant_total=0.
  - state=IDLE, hold_cnt=0, turn_cnt=0.
  - last_id=N_MASTERS-1, so master 0 has first priority.
- Reset mid-grant: en drops to 0 on the same edge; no turnaround is inserted.
- All outputs are registered. Latency is one edge from req sampled to en asserted.
- Round-robin selection: search req starting at (last_id+1) mod N_MASTERS, ascending with wrap. The first set bit wins and last_id updates to the winner.
- IDLE:
  - en=0.
  - If req!=0 at an edge: select a winner, set en=one-hot(winner), grant_id=winner, hold_cnt=0, and go to GRANT.
- GRANT:
  - en held one-hot; hold_cnt increments each cycle, saturating.
  - Release conditions, checked each edge:
    - (a) req[grant_id]==0;
    - (b) MAX_HOLD!=0 AND hold_cnt==MAX_HOLD-1 AND (req with bit grant_id masked)!=0.
  - On release: en=0, turn_cnt=0, go to TURN.
  - A lone requester holding req is never forced off.
- TURN:
  - en=0 for exactly TURN_CYCLES cycles.
  - On the edge ending the last dead cycle: if req!=0, arbitrate and go to GRANT with en set on that edge; otherwise go to IDLE.
  - A master released by (b) that still requests competes normally and loses to any other pending master.
- Invariants:
  - popcount(en)<=1 at all times.
  - en never changes directly from one non-zero value to a different non-zero value.
  - grant_id holds its value while en=0.
- Simultaneous events: if req[grant_id] drops on the same edge hold_cnt reaches its limit, release is taken once (single TURN).
- Requests raised during TURN are sampled at the arbitration edge only; earlier pulses that have disappeared are ignored.

Optional Feature:
- Macro: ARB_STATS_EN.
- Defined: grant_total port exists. It increments by 1 on each edge where a new grant is issued (IDLE/TURN -> GRANT), saturates at 255, and is cleared by reset.
- Undefined: the port and counter are absent. All other behaviour is identical.

Test Plan:
- Reset, then req=0001 for 5 cycles, then 0000 -> en=0001 from edge 1 for 5 cycles, grant_id=0; then en=0000 with 1 TURN cycle; then IDLE with bus_busy=0.
- req=1111 held constant, defaults -> en sequence 0001, 0010, 0100, 1000, 0001. Each grant lasts 8 cycles, separated by exactly 1 all-zero cycle.
- req=0100 held 30 cycles, MAX_HOLD=8 -> en=0100 continuously, no forced release, grant_id=2.
- Master 1 granted; same edge req=1000 raised and req[1] dropped -> en=0000 for TURN_CYCLES, then en=1000. popcount(en)<=1 checked every cycle.
- reset asserted during a grant of master 3 -> en=0000 next edge. With req=1111 afterwards, the first grant goes to master 0.
- ARB_STATS_EN defined, 300 grants issued -> grant_total=255 and holds; after reset, grant_total=0.
